// File: rtl/vga_pkg.sv
// Shared video timing and tile-RAM constants for the tile display path.
package vga_pkg;

    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 480;
    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 525;
    localparam int TILE_SHIFT  = 3;
    localparam int TILE_COLS   = ACTIVE_COLS >> TILE_SHIFT;
    localparam int TILE_ROWS   = ACTIVE_ROWS >> TILE_SHIFT;
    localparam int VRAM_DEPTH  = TILE_COLS * TILE_ROWS;
    localparam int ADDR_WIDTH  = 13;
    localparam int DATA_WIDTH  = 8;
    localparam int CNT_WIDTH   = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line; every stage is visible so callers can
// tap intermediate alignment points.
module pipe_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH-1:0]            din,
    output logic [DEPTH:1][WIDTH-1:0]   taps
);

    // Shift din one stage per clock; taps[DEPTH] is the fully delayed value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taps <= '0;
        end else begin
            taps[1] <= din;
            for (int i = 2; i <= DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

endmodule

// File: rtl/vram_access_arbiter.sv
// Single-port tile RAM arbiter: display reads own active cycles, a frame-clear
// sequencer and a host write port share the blanking cycles (clear first).
module vram_access_arbiter
    import vga_pkg::*;
#(
    parameter int ACTIVE_COLS = vga_pkg::ACTIVE_COLS,
    parameter int ACTIVE_ROWS = vga_pkg::ACTIVE_ROWS,
    parameter int TILE_COLS   = vga_pkg::TILE_COLS,
    parameter int TILE_ROWS   = vga_pkg::TILE_ROWS,
    parameter int ADDR_WIDTH  = vga_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = vga_pkg::DATA_WIDTH
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_HSync,
    input  logic                  i_VSync,
    input  logic [9:0]            i_Col_Count,
    input  logic [9:0]            i_Row_Count,
    input  logic                  i_Wr_Req,
    input  logic [ADDR_WIDTH-1:0] i_Wr_Addr,
    input  logic [DATA_WIDTH-1:0] i_Wr_Data,
    output logic                  o_Wr_Ack,
    output logic                  o_Wr_Err,
    input  logic                  i_Clear_Req,
    input  logic [DATA_WIDTH-1:0] i_Clear_Data,
    output logic                  o_Clear_Busy,
    output logic                  o_Clear_Done,
    output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic                  o_Mem_We,
    output logic [DATA_WIDTH-1:0] o_Mem_Wdata,
    input  logic [DATA_WIDTH-1:0] i_Mem_Rdata,
    output logic                  o_HSync,
    output logic                  o_VSync,
    output logic [9:0]            o_Col_Count,
    output logic [9:0]            o_Row_Count,
    output logic [DATA_WIDTH-1:0] o_Tile_Data,
    output logic                  o_Tile_Valid
);

    localparam int                    DEPTH       = TILE_COLS * TILE_ROWS;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] TILE_COLS_A = ADDR_WIDTH'(TILE_COLS);
    localparam logic [9:0]            COLS_C      = 10'(ACTIVE_COLS);
    localparam logic [9:0]            ROWS_C      = 10'(ACTIVE_ROWS);
    localparam int                    PW          = 2 + 10 + 10 + 1;

    logic                  active;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  in_range;

    clr_state_t            state, state_nx;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nx;
    logic [DATA_WIDTH-1:0] clr_data, clr_data_nx;
    logic                  ack_pend;

    logic [ADDR_WIDTH-1:0] addr_nx;
    logic                  we_nx;
    logic [DATA_WIDTH-1:0] wdata_nx;
    logic                  ack_nx;
    logic                  err_nx;

    logic [3:1][PW-1:0]    taps;
    logic                  unused_taps;

    assign active   = (i_Col_Count < COLS_C) && (i_Row_Count < ROWS_C);
    // Row-major tile index; max 4799 fits ADDR_WIDTH, so no overflow.
    assign rd_addr  = ADDR_WIDTH'(i_Row_Count >> TILE_SHIFT) * TILE_COLS_A
                    + ADDR_WIDTH'(i_Col_Count >> TILE_SHIFT);
    assign in_range = i_Wr_Addr < DEPTH_A;

    // Clear sequencer next-state plus the per-cycle RAM slot decision.
    always_comb begin
        state_nx    = state;
        clr_cnt_nx  = clr_cnt;
        clr_data_nx = clr_data;
        addr_nx     = o_Mem_Addr;
        we_nx       = 1'b0;
        wdata_nx    = o_Mem_Wdata;
        ack_nx      = 1'b0;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (i_Clear_Req) begin
                    state_nx    = CLEAR;
                    clr_cnt_nx  = '0;
                    clr_data_nx = i_Clear_Data;
                end
            end
            CLEAR: begin
                // Counter only moves on an issued write; it parks at the
                // terminal address rather than wrapping.
                if (!active) begin
                    if (clr_cnt == LAST_ADDR) state_nx = DONE;
                    else                      clr_cnt_nx = clr_cnt + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (active) begin
            addr_nx = rd_addr;
        end else if (state == CLEAR) begin
            addr_nx  = clr_cnt;
            we_nx    = 1'b1;
            wdata_nx = clr_data;
        end else if (state == IDLE && i_Wr_Req && !ack_pend) begin
            // ack_pend covers the cycle where the host still holds the
            // request it is about to see acked.
            ack_nx = 1'b1;
            if (in_range) begin
                addr_nx  = i_Wr_Addr;
                wdata_nx = i_Wr_Data;
                we_nx    = 1'b1;
            end else begin
                err_nx = 1'b1;
            end
        end
    end

    // Clear sequencer state, counter and latched fill value.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_data <= '0;
        end else begin
            state    <= state_nx;
            clr_cnt  <= clr_cnt_nx;
            clr_data <= clr_data_nx;
        end
    end

    // Registered RAM slot and host handshake.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            o_Mem_Addr  <= '0;
            o_Mem_We    <= 1'b0;
            o_Mem_Wdata <= '0;
            o_Wr_Ack    <= 1'b0;
            o_Wr_Err    <= 1'b0;
            ack_pend    <= 1'b0;
        end else begin
            o_Mem_Addr  <= addr_nx;
            o_Mem_We    <= we_nx;
            o_Mem_Wdata <= wdata_nx;
            o_Wr_Ack    <= ack_nx;
            o_Wr_Err    <= err_nx;
            ack_pend    <= ack_nx;
        end
    end

    assign o_Clear_Busy = (state != IDLE);
    assign o_Clear_Done = (state == DONE);

    pipe_delay #(
        .WIDTH (PW),
        .DEPTH (3)
    ) u_dly (
        .clk   (i_Clk),
        .rst_n (i_Rst_n),
        .din   ({i_HSync, i_VSync, i_Col_Count, i_Row_Count, active}),
        .taps  (taps)
    );

    assign {o_HSync, o_VSync, o_Col_Count, o_Row_Count, o_Tile_Valid} = taps[3];
    assign unused_taps = ^{taps[1], taps[2][PW-1:1]};

    // RAM data arrives with stage-2 alignment; blank it outside the active area.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) o_Tile_Data <= '0;
        else          o_Tile_Data <= taps[2][0] ? i_Mem_Rdata : '0;
    end

endmodule
